counter_seq_ctrl: RTL and testbench

//  Run-length sequencer for the lab counter datapath. Accepts a start command with

---
 rtl/counter_seq_pkg.sv | 15 +
 rtl/seq_count_core.sv | 46 ++++
 rtl/counter_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared constants for the run-length sequencer: FSM state encoding and count direction.
// Latency: n/a (constants only).
// Backpressure: n/a.
package counter_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_PAUSED = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/seq_count_core.sv
// Loadable up/down counter; load has priority over enable, arithmetic is mod 2^WIDTH.
// Latency: count updates on the clock edge after load/en are presented.
// Backpressure: none; holds its value whenever neither load nor en is asserted.
module seq_count_core
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins, otherwise step in the selected direction when enabled.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir == DIR_DOWN) begin
                count_d = count_q - 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run-length sequencer: counts start->terminal value reps+1 times, pulses done at the end.
// Latency: done arrives (reps+1)*(target+1)+1 edges after the accepted start edge.
// Backpressure: none; pause freezes the run, abort cancels it, start is ignored while busy.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [REP_W-1:0] reps,
    input  logic             dir,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic [REP_W-1:0] pass
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] reps_d;
    logic             dir_q;
    logic             dir_d;
    logic [REP_W-1:0] pass_q;
    logic [REP_W-1:0] pass_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             core_en;
    logic             core_load;
    logic [WIDTH-1:0] core_load_val;

    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic             at_term;
    logic             last_pass;

    // Start/terminal values depend only on the latched operands, never the live inputs.
    assign start_val = (dir_q == DIR_DOWN) ? target_q : '0;
    assign term_val  = (dir_q == DIR_DOWN) ? '0 : target_q;
    assign at_term   = (count == term_val);
    assign last_pass = (pass_q == reps_q);

    seq_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (core_en),
        .load     (core_load),
        .load_val (core_load_val),
        .dir      (dir_q),
        .count    (count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks pause, pause outranks terminal handling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (at_term && last_pass) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath controls: operand latch, counter load/step, pass index, wrap pulse.
    always_comb begin
        target_d      = target_q;
        reps_d        = reps_q;
        dir_d         = dir_q;
        pass_d        = pass_q;
        wrap_d        = 1'b0;
        core_en       = 1'b0;
        core_load     = 1'b0;
        core_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    target_d = target;
                    reps_d   = reps;
                    dir_d    = dir;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                pass_d    = '0;
                if (!abort) begin
                    core_load_val = start_val;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    core_load = 1'b1;
                    pass_d    = '0;
                end else if (pause) begin
                    core_en = 1'b0;
                end else if (at_term) begin
                    // Final terminal leaves the count parked for DONE.
                    if (!last_pass) begin
                        core_load     = 1'b1;
                        core_load_val = start_val;
                        pass_d        = pass_q + 1'b1;
                        wrap_d        = 1'b1;
                    end
                end else begin
                    core_en = 1'b1;
                end
            end
            ST_PAUSED, ST_DONE: begin
                if (abort) begin
                    core_load = 1'b1;
                    pass_d    = '0;
                end
            end
            default: begin
                core_load = 1'b1;
                pass_d    = '0;
            end
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSED);
        done_d = (state_d == ST_DONE);
    end

    // Registered outputs and latched operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q <= '0;
            reps_q   <= '0;
            dir_q    <= DIR_UP;
            pass_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            target_q <= target_d;
            reps_q   <= reps_d;
            dir_q    <= dir_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed scenarios plus randomized commands with pause/abort.
// Expected output trace per command is built as a list of post-edge snapshots.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic [2:0] reps;
    logic       dir;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [3:0] count;
    logic [2:0] pass;

    int n_chk;
    int n_fail;
    int prev_c;
    int prev_p;

    typedef struct {
        int c;
        int p;
        int b;
        int d;
        int w;
    } snap_t;

    snap_t q[$];
    snap_t r[$];

    counter_seq_ctrl #(
        .WIDTH (4),
        .REP_W (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .reps   (reps),
        .dir    (dir),
        .pause  (pause),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .wrap   (wrap),
        .count  (count),
        .pass   (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_snap(input string where, input snap_t e);
        chk($sformatf("%s count", where), int'(count), e.c);
        chk($sformatf("%s pass", where), int'(pass), e.p);
        chk($sformatf("%s busy", where), int'(busy), e.b);
        chk($sformatf("%s done", where), int'(done), e.d);
        chk($sformatf("%s wrap", where), int'(wrap), e.w);
    endtask

    // Expected trace: [0]=LOAD, then every visible RUN value pass by pass,
    // pause inserts pl+1 held copies, then DONE and a settled IDLE snapshot.
    // pm: post-edge index where pause is first sampled high on the next edge (0 = none).
    // ab: post-edge index after which abort is sampled (-1 = none).
    task automatic run_cmd(input string name, input int tgt, input int rp, input int dr,
                           input int pm, input int pl, input int ab);
        snap_t e;
        int    term;
        q.delete();
        r.delete();
        e = '{prev_c, prev_p, 1, 0, 0};
        q.push_back(e);
        for (int p = 0; p <= rp; p++) begin
            for (int i = 0; i <= tgt; i++) begin
                e.c = dr ? (tgt - i) : i;
                e.p = p;
                e.b = 1;
                e.d = 0;
                e.w = (p > 0 && i == 0) ? 1 : 0;
                r.push_back(e);
            end
        end
        for (int j = 1; j <= r.size(); j++) begin
            q.push_back(r[j-1]);
            if (j == pm) begin
                e   = r[j-1];
                e.w = 0;
                for (int h = 0; h <= pl; h++) q.push_back(e);
            end
        end
        term = dr ? 0 : tgt;
        e = '{term, rp, 0, 1, 0};
        q.push_back(e);
        e = '{term, rp, 0, 0, 0};
        q.push_back(e);
        if (ab >= 0 && ab <= q.size() - 2) begin
            while (q.size() > ab + 1) void'(q.pop_back());
            e = '{0, 0, 0, 0, 0};
            q.push_back(e);
        end

        target = 4'(tgt);
        reps   = 3'(rp);
        dir    = dr[0];
        start  = 1'b1;
        pause  = 1'b0;
        abort  = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            @(posedge clk);
            #1;
            chk_snap($sformatf("%s@%0d", name, k), q[k]);
            // Noise on start/operands while not idle must have no effect.
            start  = (k < q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            target = 4'($urandom);
            reps   = 3'($urandom);
            dir    = 1'($urandom);
            pause  = (pm > 0 && k + 1 >= pm + 1 && k + 1 <= pm + pl) ? 1'b1 : 1'b0;
            abort  = (ab >= 0 && k + 1 == ab + 1) ? 1'b1 : 1'b0;
        end
        start  = 1'b0;
        pause  = 1'b0;
        abort  = 1'b0;
        prev_c = q[q.size()-1].c;
        prev_p = q[q.size()-1].p;
    endtask

    // Idle cycles with pause/abort noise: nothing may move.
    task automatic idle_cycles(input string name, input int n);
        snap_t e;
        e = '{prev_c, prev_p, 0, 0, 0};
        for (int k = 0; k < n; k++) begin
            pause = 1'($urandom);
            abort = 1'($urandom);
            start = 1'b0;
            @(posedge clk);
            #1;
            chk_snap($sformatf("%s idle%0d", name, k), e);
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t e;
        int    tgt;
        int    rp;
        int    dr;
        int    pm;
        int    pl;
        int    ab;
        int    n;
        int    extra;

        n_chk  = 0;
        n_fail = 0;
        prev_c = 0;
        prev_p = 0;
        rst    = 1'b0;
        start  = 1'b0;
        target = '0;
        reps   = '0;
        dir    = 1'b0;
        pause  = 1'b0;
        abort  = 1'b0;

        #1;
        e = '{0, 0, 0, 0, 0};
        chk_snap("reset", e);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_snap("post-reset", e);

        // Directed scenarios.
        run_cmd("up3", 3, 0, 0, 0, 0, -1);
        run_cmd("down2x3", 2, 2, 1, 0, 0, -1);
        run_cmd("pause3", 3, 0, 0, 2, 3, -1);
        run_cmd("abort_run", 5, 1, 0, 0, 0, 3);
        run_cmd("tgt0", 0, 3, 0, 0, 0, -1);
        run_cmd("up15", 15, 0, 0, 0, 0, -1);
        run_cmd("abort_load", 4, 0, 1, 0, 0, 0);
        run_cmd("abort_done", 2, 0, 0, 0, 0, 4);
        run_cmd("abort_pause", 3, 1, 1, 2, 4, 4);

        // start together with abort in IDLE is refused.
        start  = 1'b1;
        abort  = 1'b1;
        target = 4'd7;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            e = '{prev_c, prev_p, 0, 0, 0};
            chk_snap($sformatf("start_abort@%0d", k), e);
        end
        start = 1'b0;
        abort = 1'b0;

        // Asynchronous reset in the middle of a run.
        run_cmd("pre_rst", 1, 0, 0, 0, 0, -1);
        target = 4'd5;
        reps   = 3'd0;
        dir    = 1'b0;
        start  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("rst_mid count before", int'(count), 2);
        chk("rst_mid busy before", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        e = '{0, 0, 0, 0, 0};
        chk_snap("rst_mid", e);
        @(negedge clk);
        rst    = 1'b1;
        prev_c = 0;
        prev_p = 0;
        idle_cycles("rst_release", 4);

        // Randomized commands.
        for (int t = 0; t < 30; t++) begin
            tgt   = $urandom_range(0, 15);
            rp    = $urandom_range(0, 7);
            dr    = $urandom_range(0, 1);
            n     = (tgt + 1) * (rp + 1);
            pm    = 0;
            pl    = 0;
            ab    = -1;
            extra = 0;
            if ($urandom_range(0, 1) == 1) begin
                pm    = $urandom_range(1, n);
                pl    = $urandom_range(1, 4);
                extra = pl + 1;
            end
            if ($urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, n + extra + 1);
            end
            run_cmd($sformatf("rnd%0d", t), tgt, rp, dr, pm, pl, ab);
            idle_cycles($sformatf("rnd%0d", t), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
